lnrv_pipe_flush_ctrl: RTL and testbench

Responder side of the EXU pipeline-flush handshake. Accepts flush requests (branch/jump/fence/mret/dret from EXU, plus trap entry from the CSR/trap unit), computes the redirect target, kills the front-end and discards stale instruction-fetch responses. It then drives a single redirect to the IFU and returns the acknowledge the requester is stalled on. Sits between EXU/commit and IFU.

---
 rtl/lnrv_pipe_flush_ctrl_pkg.sv | 25 ++
 rtl/lnrv_flush_ostd_cnt.sv | 43 ++++
 rtl/lnrv_pipe_flush_ctrl.sv | 121 ++++++++++++
 tb/tb_lnrv_pipe_flush_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lnrv_pipe_flush_ctrl_pkg.sv
// Shared types for the pipeline-flush controller: FSM state, flush source,
// default outstanding-fetch depth and the EXU redirect-target helper.
package lnrv_pipe_flush_ctrl_pkg;

   typedef enum logic [1:0] {
      FLUSH_ST_IDLE  = 2'd0,
      FLUSH_ST_DRAIN = 2'd1,
      FLUSH_ST_REDIR = 2'd2
   } flush_state_e;

   typedef enum logic {
      FLUSH_SRC_EXU  = 1'b0,
      FLUSH_SRC_TRAP = 1'b1
   } flush_src_e;

   localparam int FLUSH_OSTD_MAX = 2;

   // Jump/branch target: operand sum with bit 0 cleared (JALR semantics).
   function automatic logic [31:0] exu_target(input logic [31:0] op1, input logic [31:0] op2);
      logic [31:0] sum;
      sum = op1 + op2;
      return {sum[31:1], 1'b0};
   endfunction

endpackage

// File: rtl/lnrv_flush_ostd_cnt.sv
// lnrv_flush_ostd_cnt: saturating up/down count of outstanding IFU fetches,
// with zero flags for the current and next-cycle value.
module lnrv_flush_ostd_cnt #(
   parameter int OSTD_MAX = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic nxt_zero_o,
   output logic full_o
);

   localparam int               CNT_W   = $clog2(OSTD_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTD_MAX);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: cnt_d gets a default before any branch so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: registers update with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o     = (cnt_q == '0);
   assign nxt_zero_o = (cnt_d == '0);
   assign full_o     = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lnrv_pipe_flush_ctrl.sv
// lnrv_pipe_flush_ctrl: accepts EXU/trap flush requests, drains stale fetches,
// redirects the IFU once and acks the requester. LNRV_FLUSH_BYPASS_EN enables
// the zero-latency redirect path.
module lnrv_pipe_flush_ctrl
   import lnrv_pipe_flush_ctrl_pkg::*;
#(
   parameter int OSTD_MAX = FLUSH_OSTD_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_req,
   output logic        flush_ack,
   input  logic [31:0] flush_pc_op1,
   input  logic [31:0] flush_pc_op2,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   output logic        trap_ack,
   input  logic        ifu_req_hsk,
   input  logic        ifu_rsp_hsk,
   output logic        ifu_req_allow,
   output logic        ifu_rsp_discard,
   output logic        pipe_kill,
   output logic        ifu_redirect_vld,
   input  logic        ifu_redirect_rdy,
   output logic [31:0] ifu_redirect_pc
);

   flush_state_e state_q, state_d;
   flush_src_e   src_q, src_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         cnt_zero, cnt_nxt_zero, cnt_full;
   logic         accept, bypass;
   flush_src_e   accept_src;
   logic [31:0]  accept_tgt;

   lnrv_flush_ostd_cnt #(
      .OSTD_MAX   (OSTD_MAX)
   ) u_ostd_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (ifu_req_hsk),
      .dec_i      (ifu_rsp_hsk),
      .zero_o     (cnt_zero),
      .nxt_zero_o (cnt_nxt_zero),
      .full_o     (cnt_full)
   );

   // rst_n also masks accept so outputs show reset values while a request is held.
   assign accept     = rst_n & (state_q == FLUSH_ST_IDLE) & (trap_req | flush_req);
   assign accept_src = trap_req ? FLUSH_SRC_TRAP : FLUSH_SRC_EXU;
   assign accept_tgt = trap_req ? trap_pc : exu_target(flush_pc_op1, flush_pc_op2);

`ifdef LNRV_FLUSH_BYPASS_EN
   assign bypass = accept & cnt_zero & ~ifu_req_hsk & ifu_redirect_rdy;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      src_d = src_q;
      tgt_d = tgt_q;
      if (accept) begin
         src_d = accept_src;
         tgt_d = accept_tgt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FLUSH_ST_IDLE;
         src_q   <= FLUSH_SRC_EXU;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FLUSH_ST_IDLE: begin
            if (accept && !bypass) begin
               state_d = (!cnt_zero || !cnt_nxt_zero) ? FLUSH_ST_DRAIN : FLUSH_ST_REDIR;
            end
         end
         FLUSH_ST_DRAIN: begin
            if (cnt_nxt_zero) state_d = FLUSH_ST_REDIR;
         end
         FLUSH_ST_REDIR: begin
            if (ifu_redirect_rdy) state_d = FLUSH_ST_IDLE;
         end
         default: state_d = FLUSH_ST_IDLE;
      endcase
   end

   always_comb begin
      pipe_kill        = accept | (state_q != FLUSH_ST_IDLE);
      ifu_rsp_discard  = pipe_kill;
      ifu_req_allow    = ~cnt_full & ~pipe_kill;
      ifu_redirect_vld = 1'b0;
      ifu_redirect_pc  = '0;
      flush_ack        = 1'b0;
      trap_ack         = 1'b0;
      if (state_q == FLUSH_ST_REDIR) begin
         ifu_redirect_vld = 1'b1;
         ifu_redirect_pc  = tgt_q;
         if (ifu_redirect_rdy) begin
            flush_ack = (src_q == FLUSH_SRC_EXU);
            trap_ack  = (src_q == FLUSH_SRC_TRAP);
         end
      end else if (bypass) begin
         ifu_redirect_vld = 1'b1;
         ifu_redirect_pc  = accept_tgt;
         flush_ack        = (accept_src == FLUSH_SRC_EXU);
         trap_ack         = (accept_src == FLUSH_SRC_TRAP);
      end
   end

endmodule

// File: tb/tb_lnrv_pipe_flush_ctrl.sv
// Self-checking bench for lnrv_pipe_flush_ctrl: directed vector table, reset and
// bypass sequences, then random traffic against a cycle-level behavioural model.
module tb_lnrv_pipe_flush_ctrl;

   localparam int OSTD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_req = 1'b0, trap_req = 1'b0;
   logic [31:0] flush_pc_op1 = '0, flush_pc_op2 = '0, trap_pc = '0;
   logic        ifu_req_hsk = 1'b0, ifu_rsp_hsk = 1'b0, ifu_redirect_rdy = 1'b0;
   logic        flush_ack, trap_ack, ifu_req_allow, ifu_rsp_discard, pipe_kill;
   logic        ifu_redirect_vld;
   logic [31:0] ifu_redirect_pc;

   int n_checks = 0;
   int n_err    = 0;

   lnrv_pipe_flush_ctrl #(.OSTD_MAX(OSTD)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush_req        (flush_req),
      .flush_ack        (flush_ack),
      .flush_pc_op1     (flush_pc_op1),
      .flush_pc_op2     (flush_pc_op2),
      .trap_req         (trap_req),
      .trap_pc          (trap_pc),
      .trap_ack         (trap_ack),
      .ifu_req_hsk      (ifu_req_hsk),
      .ifu_rsp_hsk      (ifu_rsp_hsk),
      .ifu_req_allow    (ifu_req_allow),
      .ifu_rsp_discard  (ifu_rsp_discard),
      .pipe_kill        (pipe_kill),
      .ifu_redirect_vld (ifu_redirect_vld),
      .ifu_redirect_rdy (ifu_redirect_rdy),
      .ifu_redirect_pc  (ifu_redirect_pc)
   );

   always #5 clk = ~clk;

   // Output bundle: {flush_ack, trap_ack, allow, discard, kill, vld, pc[31:0]}
   function automatic logic [37:0] outs();
      return {flush_ack, trap_ack, ifu_req_allow, ifu_rsp_discard, pipe_kill,
              ifu_redirect_vld, ifu_redirect_pc};
   endfunction

   function automatic logic [37:0] want(input logic fack, input logic tack, input logic allow,
                                        input logic kill, input logic vld, input logic [31:0] pc);
      return {fack, tack, allow, kill, kill, vld, pc};
   endfunction

   task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got fack/tack/allow/disc/kill/vld=%b pc=%h, expected %b pc=%h",
                  name, got[37:32], got[31:0], exp[37:32], exp[31:0]);
      end
   endtask

   typedef struct {
      logic        fr, tr;
      logic [31:0] op1, op2, tpc;
      logic        rq, rs, rdy;
      logic [37:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic fr, input logic tr, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [31:0] tpc,
                               input logic rq, input logic rs, input logic rdy,
                               input logic fack, input logic tack, input logic allow,
                               input logic kill, input logic vld, input logic [31:0] pc);
      vec_t v;
      v.fr = fr; v.tr = tr; v.op1 = op1; v.op2 = op2; v.tpc = tpc;
      v.rq = rq; v.rs = rs; v.rdy = rdy;
      v.exp = want(fack, tack, allow, kill, vld, pc);
      return v;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; flush_req = 1'b0; trap_req = 1'b0;
      ifu_req_hsk = 1'b0; ifu_rsp_hsk = 1'b0; ifu_redirect_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Behavioural model state for the random phase.
   int          ostd, acc_cyc;
   bit          busy, cap_trap, need_drain;
   logic [31:0] cap_pc;
   bit          fl_taken, tr_taken, fl_ackd, tr_ackd;

   initial begin
      // Reset state while rst_n is low.
      #3;
      check("reset_state", outs(), want(0, 0, 1, 0, 0, 32'h0));
      @(posedge clk); #1 rst_n = 1'b1; ifu_redirect_rdy = 1'b1;

`ifndef LNRV_FLUSH_BYPASS_EN
      //        fr tr op1           op2           tpc           rq rs rdy  fa ta al kl vl pc
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h8000_0100, 32'hFFFF_FFF0, 32'h0,       0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h8000_0100, 32'hFFFF_FFF0, 32'h0,       0, 0, 1,  1, 0, 0, 1, 1, 32'h8000_00F0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h0000_1003, 32'h0,        32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 1,  1, 0, 0, 1, 1, 32'h0000_1002));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      // Request dropped right after accept still completes.
      tbl.push_back(mk(1, 0, 32'h0000_0300, 32'h7,        32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 0, 0, 1, 1, 32'h0000_0306));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      // Trap and EXU together: trap first, EXU afterwards.
      tbl.push_back(mk(1, 1, 32'h100,      32'h4,        32'h200,      0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h100,      32'h4,        32'h200,      0, 0, 1,  0, 1, 0, 1, 1, 32'h200));
      tbl.push_back(mk(1, 0, 32'h100,      32'h4,        32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h100,      32'h4,        32'h0,        0, 0, 1,  1, 0, 0, 1, 1, 32'h104));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      // Redirect stalled by rdy low for 4 cycles.
      tbl.push_back(mk(1, 0, 32'h40,       32'h3,        32'h0,        0, 0, 0,  0, 0, 0, 1, 0, 32'h0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 32'h40,    32'h3,        32'h0,        0, 0, 0,  0, 0, 0, 1, 1, 32'h42));
      tbl.push_back(mk(1, 0, 32'h40,       32'h3,        32'h0,        0, 0, 1,  1, 0, 0, 1, 1, 32'h42));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      // Counter saturation and underflow.
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 0, 0, 0, 32'h0));
      // Two outstanding, request at c0, responses at c3 and c5, REDIR at c6.
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 1, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 0, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 1, 1,  0, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000,     32'h10,       32'h0,        0, 0, 1,  1, 0, 0, 1, 1, 32'h1010));
      tbl.push_back(mk(0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  0, 0, 1, 0, 0, 32'h0));

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         flush_req = tbl[i].fr; trap_req = tbl[i].tr;
         flush_pc_op1 = tbl[i].op1; flush_pc_op2 = tbl[i].op2; trap_pc = tbl[i].tpc;
         ifu_req_hsk = tbl[i].rq; ifu_rsp_hsk = tbl[i].rs; ifu_redirect_rdy = tbl[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end
`endif

      // Reset during a stalled redirect: back to IDLE, no ack.
      @(posedge clk); #1;
      flush_req = 1'b1; flush_pc_op1 = 32'h2000; flush_pc_op2 = 32'h0;
      ifu_req_hsk = 1'b0; ifu_rsp_hsk = 1'b0; ifu_redirect_rdy = 1'b0;
      @(negedge clk);
      check("rstmid_accept", outs(), want(0, 0, 0, 1, 0, 32'h0));
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_wait1", outs(), want(0, 0, 0, 1, 1, 32'h2000));
      @(posedge clk); #1 rst_n = 1'b0;
      #1 check("rstmid_async", outs(), want(0, 0, 1, 0, 0, 32'h0));
      @(negedge clk);
      check("rstmid_hold", outs(), want(0, 0, 1, 0, 0, 32'h0));
      @(posedge clk); #1 flush_req = 1'b0; ifu_redirect_rdy = 1'b1; rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_idle", outs(), want(0, 0, 1, 0, 0, 32'h0));

`ifdef LNRV_FLUSH_BYPASS_EN
      @(posedge clk); #1;
      flush_req = 1'b1; flush_pc_op1 = 32'h0000_5001; flush_pc_op2 = 32'h10;
      @(negedge clk);
      check("bypass_c0", outs(), want(1, 0, 0, 1, 1, 32'h0000_5010));
      @(posedge clk); #1 flush_req = 1'b0;
      @(negedge clk);
      check("bypass_c1", outs(), want(0, 0, 1, 0, 0, 32'h0));
`endif

      // Random traffic against the behavioural model.
      do_reset();
      ostd = 0; busy = 0; fl_taken = 0; tr_taken = 0; fl_ackd = 0; tr_ackd = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        acc, kill, in_redir, byp;
         logic [31:0] tgt, exp_pc;
         logic        fack, tack, vld;
         @(posedge clk); #1;
         if (fl_ackd) begin
            flush_req = 1'b0; fl_ackd = 0; fl_taken = 0;
         end else if (!flush_req && $urandom_range(7) == 0) begin
            flush_req = 1'b1; flush_pc_op1 = $urandom; flush_pc_op2 = $urandom;
         end else if (fl_taken) begin
            flush_pc_op1 = $urandom; flush_pc_op2 = $urandom;
         end
         if (tr_ackd) begin
            trap_req = 1'b0; tr_ackd = 0; tr_taken = 0;
         end else if (!trap_req && $urandom_range(11) == 0) begin
            trap_req = 1'b1; trap_pc = $urandom;
         end else if (tr_taken) begin
            trap_pc = $urandom;
         end
         acc  = !busy && (flush_req || trap_req);
         kill = busy || acc;
         ifu_req_hsk      = !kill && ($urandom_range(2) == 0);
         ifu_rsp_hsk      = ($urandom_range(2) == 0);
         ifu_redirect_rdy = ($urandom_range(3) != 0);
         @(negedge clk);

         tgt = trap_req ? trap_pc : ((flush_pc_op1 + flush_pc_op2) & 32'hFFFF_FFFE);
         in_redir = busy && (cyc >= acc_cyc + 1 + int'(need_drain)) && (ostd == 0);
         byp = 1'b0;
`ifdef LNRV_FLUSH_BYPASS_EN
         byp = acc && (ostd == 0) && !ifu_req_hsk && ifu_redirect_rdy;
`endif
         vld    = in_redir || byp;
         exp_pc = in_redir ? cap_pc : (byp ? tgt : 32'h0);
         fack   = (in_redir && ifu_redirect_rdy && !cap_trap) || (byp && !trap_req);
         tack   = (in_redir && ifu_redirect_rdy && cap_trap) || (byp && trap_req);
         check($sformatf("rand%0d", cyc), outs(),
               want(fack, tack, (ostd < OSTD) && !kill, kill, vld, exp_pc));

         if (in_redir && ifu_redirect_rdy) begin
            busy = 0;
            if (cap_trap) tr_ackd = 1; else fl_ackd = 1;
         end
         if (byp) begin
            if (trap_req) tr_ackd = 1; else fl_ackd = 1;
         end else if (acc) begin
            busy = 1; cap_trap = trap_req; cap_pc = tgt; acc_cyc = cyc;
            need_drain = (ostd != 0);
            if (trap_req) tr_taken = 1; else fl_taken = 1;
         end
         if (ifu_req_hsk && !ifu_rsp_hsk && ostd < OSTD) ostd++;
         else if (ifu_rsp_hsk && !ifu_req_hsk && ostd > 0) ostd--;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
